reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the single-cycle/pipelined MIPS datapath; successor to the 32x32 2-read/1-write file.
- Adds configurable width, depth and read-port count, a second write port, write-to-read bypass, an asynchronous clear, and a per-register busy scoreboard for in-flight loads.
- Sits between the decode stage (reads, busy checks) and the writeback stage (writes).

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 58 +++++
 rtl/reg_file_mp.sv | 91 +++++++++
 tb/tb_reg_file_mp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   RF_DATA_W / RF_ADDR_W : default register width and address width.
//   port_lsb()            : LSB position of port <port> inside a flat bus
//                           made of equal <width>-bit fields.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  // Port i of a packed multi-port bus occupies [i*width +: width].
  function automatic int unsigned port_lsb(input int unsigned port,
                                           input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for in-flight loads.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears all busy bits)
//   busy_set    : mark register busy_addr as pending on the next edge
//   busy_addr   : register to mark pending
//   clr_en      : load return (port-1 write enable), clears busy on clr_addr
//   clr_addr    : register whose load is returning
//   ra          : NUM_RD packed read addresses
//   rd_busy     : bit i = busy flag of register ra[i], masked by a same-cycle
//                 load return to that register
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Set is applied after clear so a new load issued behind a returning one
  // to the same register keeps it busy.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves it unassigned would infer a latch.
    busy_nxt = busy;
    if (clr_en)   busy_nxt[clr_addr]  = 1'b0;
    if (busy_set) busy_nxt[busy_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_lookup
    logic [ADDR_W-1:0] a;
    assign a = ra[port_lsb(g, ADDR_W) +: ADDR_W];
    // A load returning this cycle already supplies the data via bypass.
    assign rd_busy[g] = busy[a] & ~(clr_en && (clr_addr == a));
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with bypass and load scoreboard.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (clears registers
//                    and busy bits; rd / rd_busy read 0 while held)
//   we0/wa0/wd0    : write port 0 (ALU writeback)
//   we1/wa1/wd1    : write port 1 (load writeback), wins address collisions
//   ra             : NUM_RD packed read addresses
//   rd             : NUM_RD packed combinational read data (with bypass)
//   busy_set/addr  : mark a register pending for an issued load
//   rd_busy        : busy flag per read port
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic wr0_ok, wr1_ok, wr0_eff;
  logic busy_set_ok;

  // Writes (and busy marks) to the hardwired zero register are dropped.
  assign wr0_ok      = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok      = we1 && !((ZERO_REG != 0) && (wa1 == '0));
  assign wr0_eff     = wr0_ok && !(wr1_ok && (wa0 == wa1));
  assign busy_set_ok = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset here because every register must
      // read 0 after reset; this forces flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr0_eff) mem[wa0] <= wd0;
      if (wr1_ok)  mem[wa1] <= wd1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_read
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] data;

    assign a = ra[port_lsb(g, ADDR_W) +: ADDR_W];

    // Port 1 bypass is evaluated last so it overrides port 0, matching the
    // write-collision rule.
    always_comb begin
      data = mem[a];
      if (we0 && (wa0 == a)) data = wd0;
      if (we1 && (wa1 == a)) data = wd1;
      if (((ZERO_REG != 0) && (a == '0)) || !rst_n) data = '0;
    end

    assign rd[port_lsb(g, DATA_W) +: DATA_W] = data;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy_set  (busy_set_ok),
    .busy_addr (busy_addr),
    .clr_en    (we1),
    .clr_addr  (wa1),
    .ra        (ra),
    .rd_busy   (rd_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default build (32x32, 2 read ports) and
// a narrow build (16-bit, 8 registers, 4 read ports). Expectations are queued
// as stimulus is applied and drained against the outputs once they settle.
module tb_reg_file_mp;

  logic clk;
  logic rst_n;

  // Default build
  logic        we0_a, we1_a, busy_set_a;
  logic [4:0]  wa0_a, wa1_a, busy_addr_a;
  logic [31:0] wd0_a, wd1_a;
  logic [9:0]  ra_a;
  logic [63:0] rd_a;
  logic [1:0]  rd_busy_a;

  // Narrow build
  logic        we0_b, we1_b, busy_set_b;
  logic [2:0]  wa0_b, wa1_b, busy_addr_b;
  logic [15:0] wd0_b, wd1_b;
  logic [11:0] ra_b;
  logic [63:0] rd_b;
  logic [3:0]  rd_busy_b;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       tag;
    int          dut;   // 0: default build, 1: narrow build
    int          kind;  // 0: rd, 1: rd_busy
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  reg_file_mp dut_a (
    .clk(clk), .rst_n(rst_n),
    .we0(we0_a), .wa0(wa0_a), .wd0(wd0_a),
    .we1(we1_a), .wa1(wa1_a), .wd1(wd1_a),
    .ra(ra_a), .rd(rd_a),
    .busy_set(busy_set_a), .busy_addr(busy_addr_a), .rd_busy(rd_busy_a)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .we0(we0_b), .wa0(wa0_b), .wd0(wd0_b),
    .we1(we1_b), .wa1(wa1_b), .wd1(wd1_b),
    .ra(ra_b), .rd(rd_b),
    .busy_set(busy_set_b), .busy_addr(busy_addr_b), .rd_busy(rd_busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input int dut, input int kind,
                      input int port, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.dut  = dut;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input exp_t e);
    if (e.dut == 0 && e.kind == 0) return rd_a[e.port*32 +: 32];
    if (e.dut == 0)                return {31'b0, rd_busy_a[e.port]};
    if (e.kind == 0)               return {16'b0, rd_b[e.port*16 +: 16]};
    return {31'b0, rd_busy_b[e.port]};
  endfunction

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic drain();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e), e.val);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    we0_a = 1'b0; we1_a = 1'b0; busy_set_a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    wa0_a = '0; wa1_a = '0; wd0_a = '0; wd1_a = '0; busy_addr_a = '0; ra_a = '0;
    we0_b = 1'b0; we1_b = 1'b0; busy_set_b = 1'b0;
    wa0_b = '0; wa1_b = '0; wd0_b = '0; wd1_b = '0; busy_addr_b = '0; ra_b = '0;

    // Reset state
    ra_a = {5'd3, 5'd9};
    push("reset_rd0", 0, 0, 0, 32'd0);
    push("reset_rd1", 0, 0, 1, 32'd0);
    push("reset_busy0", 0, 1, 0, 32'd0);
    push("reset_busy1", 0, 1, 1, 32'd0);
    drain();
    #1 rst_n = 1'b1;
    tick();

    // Write R9=10 (same-cycle bypass visible), then mark R9 busy
    we0_a = 1'b1; wa0_a = 5'd9; wd0_a = 32'd10; ra_a = {5'd10, 5'd9};
    push("pre_bypass_r9", 0, 0, 0, 32'd10);
    drain();
    tick();
    idle_a();
    busy_set_a = 1'b1; busy_addr_a = 5'd9;
    tick();
    idle_a();
    push("pre_r9", 0, 0, 0, 32'd10);
    push("pre_busy_r9", 0, 1, 0, 32'd1);
    drain();

    // Reset mid-run with a write in flight
    rst_n = 1'b0;
    we0_a = 1'b1; wa0_a = 5'd9; wd0_a = 32'd55;
    push("midrst_rd0", 0, 0, 0, 32'd0);
    push("midrst_busy0", 0, 1, 0, 32'd0);
    drain();
    #18;
    idle_a();
    rst_n = 1'b1;
    tick();
    push("postrst_r9", 0, 0, 0, 32'd0);
    push("postrst_busy0", 0, 1, 0, 32'd0);
    drain();

    // Basic write/read on consecutive edges
    we0_a = 1'b1; wa0_a = 5'd9; wd0_a = 32'd10;
    tick();
    wa0_a = 5'd10; wd0_a = 32'd20;
    tick();
    idle_a();
    ra_a = {5'd10, 5'd9};
    push("basic_r9", 0, 0, 0, 32'd10);
    push("basic_r10", 0, 0, 1, 32'd20);
    drain();

    // Collision with bypass: port 1 wins
    ra_a = {5'd6, 5'd5};
    we0_a = 1'b1; wa0_a = 5'd5; wd0_a = 32'h11;
    we1_a = 1'b1; wa1_a = 5'd5; wd1_a = 32'h22;
    push("coll_bypass", 0, 0, 0, 32'h22);
    push("unwritten_r6", 0, 0, 1, 32'h0);
    drain();
    tick();
    idle_a();
    push("coll_stored", 0, 0, 0, 32'h22);
    drain();
    we0_a = 1'b1; wa0_a = 5'd6; wd0_a = 32'h44;
    push("bypass_port0", 0, 0, 1, 32'h44);
    drain();
    tick();
    idle_a();

    // Zero register: writes, bypass and busy marks ignored
    ra_a = {5'd6, 5'd0};
    we0_a = 1'b1; wa0_a = 5'd0; wd0_a = 32'hFFFF;
    busy_set_a = 1'b1; busy_addr_a = 5'd0;
    push("zero_nobypass", 0, 0, 0, 32'h0);
    drain();
    tick();
    idle_a();
    push("zero_rd", 0, 0, 0, 32'h0);
    push("zero_busy", 0, 1, 0, 32'h0);
    push("r6_stored", 0, 0, 1, 32'h44);
    drain();

    // Scoreboard: set, load return, set-over-clear, port-0 write
    ra_a = {5'd7, 5'd7};
    busy_set_a = 1'b1; busy_addr_a = 5'd7;
    push("sb_set_same_cycle", 0, 1, 0, 32'd0);
    drain();
    tick();
    idle_a();
    push("sb_set_next", 0, 1, 0, 32'd1);
    drain();
    we1_a = 1'b1; wa1_a = 5'd7; wd1_a = 32'h33;
    push("sb_return_busy", 0, 1, 0, 32'd0);
    push("sb_return_data", 0, 0, 0, 32'h33);
    drain();
    tick();
    idle_a();
    push("sb_cleared", 0, 1, 1, 32'd0);
    push("sb_stored", 0, 0, 1, 32'h33);
    drain();
    busy_set_a = 1'b1; busy_addr_a = 5'd7;
    we1_a = 1'b1; wa1_a = 5'd7; wd1_a = 32'h44;
    push("sb_setclr_same", 0, 1, 0, 32'd0);
    drain();
    tick();
    idle_a();
    push("sb_set_wins", 0, 1, 0, 32'd1);
    push("sb_setclr_data", 0, 0, 0, 32'h44);
    drain();
    we0_a = 1'b1; wa0_a = 5'd7; wd0_a = 32'h55;
    tick();
    idle_a();
    push("sb_port0_keeps", 0, 1, 1, 32'd1);
    push("sb_port0_data", 0, 0, 1, 32'h55);
    drain();

    // Narrow build: R1..R7 = 1..7, read 1,3,5,7 on four ports
    for (int i = 1; i < 8; i++) begin
      we0_b = 1'b1; wa0_b = 3'(i); wd0_b = 16'(i);
      tick();
    end
    we0_b = 1'b0;
    ra_b = {3'd7, 3'd5, 3'd3, 3'd1};
    push("b_port0", 1, 0, 0, 32'd1);
    push("b_port1", 1, 0, 1, 32'd3);
    push("b_port2", 1, 0, 2, 32'd5);
    push("b_port3", 1, 0, 3, 32'd7);
    push("b_busy3", 1, 1, 3, 32'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
